uart_transceiver: RTL and testbench
===================================

Name: uart_transceiver

Overview:
- Full-duplex 8N1 UART with ready/valid byte interfaces on both sides.
- Serialises bytes from a parallel transmit port onto serial_out.
- Deserialises serial_in into bytes on a parallel receive port.
- Used as the on-chip UART behind the CPU's memory-mapped I/O, and as the off-chip host model in system benches; two instances loop back by crossing serial_out/serial_in.

Parameters:
- CLOCK_FREQ, 125_000_000, system clock frequency in Hz.
- BAUD_RATE, 115_200, serial bit rate in bit/s.
- Derived SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE, integer division; 1085 cycles at the defaults.
- Derived SAMPLE_TIME = SYMBOL_EDGE_TIME / 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  8  byte to transmit.
- data_in_valid  input  1  data_in is valid.
- data_in_ready  output  1  transmitter can accept a byte.
- data_out  output  8  received byte.
- data_out_valid  output  1  data_out holds an unconsumed byte.
- data_out_ready  input  1  consumer accepts data_out.
- serial_in  input  1  serial receive line, idle high, asynchronous.
- serial_out  output  1  serial transmit line, idle high.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: serial_out=1, data_in_ready=1, data_out_valid=0, data_out=0; all counters cleared.
- Reset asserted mid-frame aborts TX and RX immediately. serial_out returns to 1 on the next edge, and any partial byte is discarded.
- Frame format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly SYMBOL_EDGE_TIME cycles, so a full frame is 10*SYMBOL_EDGE_TIME cycles.
- TX handshake: a transfer occurs on an edge where data_in_valid && data_in_ready. data_in is latched on that edge.
- TX timing:
  - The cycle after the handshake, data_in_ready=0 and serial_out=0 (start bit).
  - Bits follow back to back.
  - data_in_ready returns to 1 once the stop bit's full SYMBOL_EDGE_TIME has elapsed.
  - data_in_valid while not ready is ignored.
  - data_in may change after the handshake without corrupting the frame.
- Back-to-back TX: if valid is held high, the next start bit begins 1 cycle after ready reasserts. There is no extra idle gap requirement.
- RX input: serial_in passes through a 2-flop synchronizer before use, adding 2 cycles of latency.
- RX idle:
  - A synchronized 0 while idle starts a frame.
  - Each bit is sampled at SAMPLE_TIME into its bit period: start, d0..d7, stop.
  - If the start-bit sample reads 1 (glitch), return to idle with no output.
- RX completion:
  - At the stop-bit sample, data_out is updated with the 8 data bits and data_out_valid=1.
  - The stop bit value is not checked; a framing error still delivers the byte.
- RX handshake:
  - data_out_valid stays 1 and data_out stays stable until an edge with data_out_ready=1; valid is 0 the next cycle.
  - data_out_ready while valid=0 has no effect.
- RX overrun: while data_out_valid=1 the receiver does not start new frames. Incoming start bits are ignored, and the pending byte is never overwritten.
- RX re-arm: after the stop-bit sample the receiver is idle again and can accept the next start edge half a bit later (mid-stop to next start).
- TX and RX are fully independent; simultaneous activity in both directions is required.
- RX state machine: IDLE -> START (sample mid start) -> DATA (8 samples, bit counter 0..7) -> STOP -> IDLE/HOLD.
- TX state machine: IDLE -> SHIFT (10-bit shift register {1,data,0}, bit counter 0..9) -> IDLE.
- Counters are sized $clog2(SYMBOL_EDGE_TIME) bits and wrap to 0 at SYMBOL_EDGE_TIME-1.

Decomposition:
- Shared package uart_pkg: frame constants (DATA_BITS=8, FRAME_BITS=10, IDLE_LEVEL=1) and a helper function computing SYMBOL_EDGE_TIME from the two parameters.
- Sub-module uart_transmitter: data_in*, serial_out.
- Sub-module uart_receiver: serial_in, data_out*.
- uart_transceiver only instantiates and wires the two sub-modules.

Test Plan:
- Loopback of two instances at 125 MHz/115200; after reset send 0x7A -> the other instance's data_out_valid=1 with data_out=0x7A within 11*1085 cycles. The bench prints "Got 7a".
- TX waveform: send 0xA5 -> serial_out is 0 for 1085 cycles, then bits 1,0,1,0,0,1,0,1 each 1085 cycles, then 1. data_in_ready=0 for exactly 10*1085 cycles.
- Backpressure: receive 0x11 then send 0x22 while data_out_ready=0 -> data_out stays 0x11 with valid=1. Pulsing ready for 1 cycle clears valid next cycle; 0x22 is not delivered.
- Back-to-back TX of 0x00, 0xFF with valid held -> receiver delivers 0x00 then 0xFF. Each is consumed with a 1-cycle data_out_ready pulse.
- Reset mid-frame: assert reset during bit 4 of a 0x55 transmission -> serial_out=1 and data_in_ready=1 the next edge. The receiver never asserts valid for the aborted frame.
- Glitch: drive serial_in low for 100 cycles (< SAMPLE_TIME) while idle -> no data_out_valid. A subsequent valid 0x3C frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and types for the 8N1 UART transmitter/receiver pair.
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Clock cycles per serial bit (integer division, truncating).
    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_receiver.sv
// 8N1 deserialiser: synchronises serial_in, samples each bit mid-period and
// presents the byte on a ready/valid port. A pending byte blocks new frames.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_out_valid,
    input  logic                 data_out_ready
);

    localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int SAMPLE_TIME = SYMBOL_EDGE_TIME / 2;
    localparam int CW = $clog2(SYMBOL_EDGE_TIME);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] SYMBOL_LAST = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_TIME - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_BITS - 1);

    logic [1:0]           sync_r;
    logic                 rx_bit_s;
    rx_state_t            state_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [BW-1:0]        bit_cnt_r;
    logic [CW-1:0]        clk_cnt_r;
    logic [DATA_BITS-1:0] data_r;
    logic                 valid_r;

    // Two-flop synchroniser for the asynchronous serial line.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= {2{IDLE_LEVEL}};
        end else begin
            sync_r <= {sync_r[0], serial_in};
        end
    end

    assign rx_bit_s = sync_r[1];

    // Frame sampler and output holding register with consumer handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= RX_IDLE;
            shift_r   <= '0;
            bit_cnt_r <= '0;
            clk_cnt_r <= '0;
            data_r    <= '0;
            valid_r   <= 1'b0;
        end else begin
            if (valid_r && data_out_ready) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
            case (state_r)
                RX_IDLE: begin
                    clk_cnt_r <= '0;
                    bit_cnt_r <= '0;
                    // A pending byte blocks new frames so it is never overwritten.
                    if (!valid_r && (rx_bit_s == ~IDLE_LEVEL)) begin
                        state_r <= RX_START;
                    end else begin
                        state_r <= RX_IDLE;
                    end
                end
                RX_START: begin
                    if (clk_cnt_r == SAMPLE_LAST) begin
                        clk_cnt_r <= '0;
                        // A line back at idle mid start bit was only a glitch.
                        state_r <= (rx_bit_s == IDLE_LEVEL) ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (clk_cnt_r == SYMBOL_LAST) begin
                        clk_cnt_r <= '0;
                        shift_r   <= {rx_bit_s, shift_r[DATA_BITS-1:1]};
                        if (bit_cnt_r == BIT_LAST) begin
                            state_r <= RX_STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BW'(1);
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (clk_cnt_r == SYMBOL_LAST) begin
                        // Stop level is not checked; the byte is delivered regardless.
                        clk_cnt_r <= '0;
                        data_r    <= shift_r;
                        valid_r   <= 1'b1;
                        state_r   <= RX_IDLE;
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= RX_IDLE;
                end
            endcase
        end
    end

    assign data_out       = data_r;
    assign data_out_valid = valid_r;

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 serialiser: accepts a byte on a ready/valid handshake and shifts out
// {stop, data[7:0], start} LSB first, one bit every SYMBOL_EDGE_TIME cycles.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    output logic                 serial_out
);

    localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int CW = $clog2(SYMBOL_EDGE_TIME);
    localparam int BW = $clog2(FRAME_BITS);
    localparam logic [CW-1:0] SYMBOL_LAST = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(FRAME_BITS - 1);

    tx_state_t             state_r;
    logic [FRAME_BITS-1:0] shift_r;
    logic [BW-1:0]         bit_cnt_r;
    logic [CW-1:0]         clk_cnt_r;
    logic                  ready_r;
    logic                  serial_r;

    // Frame sequencer: latch the byte on handshake, then walk the ten frame bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= TX_IDLE;
            shift_r   <= {FRAME_BITS{IDLE_LEVEL}};
            bit_cnt_r <= '0;
            clk_cnt_r <= '0;
            ready_r   <= 1'b1;
            serial_r  <= IDLE_LEVEL;
        end else begin
            case (state_r)
                TX_IDLE: begin
                    clk_cnt_r <= '0;
                    bit_cnt_r <= '0;
                    if (data_in_valid) begin
                        // Start bit goes out on the very next cycle.
                        shift_r  <= {IDLE_LEVEL, data_in, ~IDLE_LEVEL};
                        serial_r <= ~IDLE_LEVEL;
                        ready_r  <= 1'b0;
                        state_r  <= TX_SHIFT;
                    end else begin
                        serial_r <= IDLE_LEVEL;
                        ready_r  <= 1'b1;
                    end
                end
                TX_SHIFT: begin
                    if (clk_cnt_r == SYMBOL_LAST) begin
                        clk_cnt_r <= '0;
                        if (bit_cnt_r == BIT_LAST) begin
                            // Stop bit fully elapsed: line idles, accept next byte.
                            state_r  <= TX_IDLE;
                            serial_r <= IDLE_LEVEL;
                            ready_r  <= 1'b1;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BW'(1);
                            serial_r  <= shift_r[1];
                            shift_r   <= {IDLE_LEVEL, shift_r[FRAME_BITS-1:1]};
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r  <= TX_IDLE;
                    serial_r <= IDLE_LEVEL;
                    ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign data_in_ready = ready_r;
    assign serial_out    = serial_r;

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: independent transmitter and receiver sharing a clock.
module uart_transceiver
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_out_valid,
    input  logic                 data_out_ready,
    input  logic                 serial_in,
    output logic                 serial_out
);

    uart_transmitter #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) u_tx (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .serial_out   (serial_out)
    );

    uart_receiver #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) u_rx (
        .clk           (clk),
        .reset         (reset),
        .serial_in     (serial_in),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready)
    );

endmodule

// File: tb/tb_uart_transceiver.sv
// Loopback bench: one instance pair at the default rate, one at a fast rate.
module tb_uart_transceiver;

    localparam int SLOW_CLK  = 125_000_000;
    localparam int SLOW_BAUD = 115_200;
    localparam int SLOW_SET  = SLOW_CLK / SLOW_BAUD;
    localparam int FAST_CLK  = 1_000_000;
    localparam int FAST_BAUD = 57_600;
    localparam int FAST_SET  = FAST_CLK / FAST_BAUD;

    logic clk = 1'b0;
    always #4 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Slow pair (sa <-> sb), sb's receive line can be overridden for glitches.
    logic       s_reset, glitch_en, glitch_line, sb_rx;
    logic [7:0] sa_din, sa_dout, sb_din, sb_dout;
    logic       sa_din_valid, sa_din_ready, sa_dout_valid, sa_dout_ready, sa_tx;
    logic       sb_din_valid, sb_din_ready, sb_dout_valid, sb_dout_ready, sb_tx;
    assign sb_rx = glitch_en ? glitch_line : sa_tx;

    // Fast pair (fa <-> fb).
    logic       f_reset;
    logic [7:0] fa_din, fa_dout, fb_din, fb_dout;
    logic       fa_din_valid, fa_din_ready, fa_dout_valid, fa_dout_ready, fa_tx;
    logic       fb_din_valid, fb_din_ready, fb_dout_valid, fb_dout_ready, fb_tx;

    uart_transceiver #(.CLOCK_FREQ(SLOW_CLK), .BAUD_RATE(SLOW_BAUD)) u_sa (
        .clk(clk), .reset(s_reset), .data_in(sa_din), .data_in_valid(sa_din_valid),
        .data_in_ready(sa_din_ready), .data_out(sa_dout), .data_out_valid(sa_dout_valid),
        .data_out_ready(sa_dout_ready), .serial_in(sb_tx), .serial_out(sa_tx));
    uart_transceiver #(.CLOCK_FREQ(SLOW_CLK), .BAUD_RATE(SLOW_BAUD)) u_sb (
        .clk(clk), .reset(s_reset), .data_in(sb_din), .data_in_valid(sb_din_valid),
        .data_in_ready(sb_din_ready), .data_out(sb_dout), .data_out_valid(sb_dout_valid),
        .data_out_ready(sb_dout_ready), .serial_in(sb_rx), .serial_out(sb_tx));
    uart_transceiver #(.CLOCK_FREQ(FAST_CLK), .BAUD_RATE(FAST_BAUD)) u_fa (
        .clk(clk), .reset(f_reset), .data_in(fa_din), .data_in_valid(fa_din_valid),
        .data_in_ready(fa_din_ready), .data_out(fa_dout), .data_out_valid(fa_dout_valid),
        .data_out_ready(fa_dout_ready), .serial_in(fb_tx), .serial_out(fa_tx));
    uart_transceiver #(.CLOCK_FREQ(FAST_CLK), .BAUD_RATE(FAST_BAUD)) u_fb (
        .clk(clk), .reset(f_reset), .data_in(fb_din), .data_in_valid(fb_din_valid),
        .data_in_ready(fb_din_ready), .data_out(fb_dout), .data_out_valid(fb_dout_valid),
        .data_out_ready(fb_dout_ready), .serial_in(fa_tx), .serial_out(fb_tx));

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fa_send(input logic [7:0] b);
        int n = 0;
        while (fa_din_ready !== 1'b1 && n < 12 * FAST_SET) begin tick(); n++; end
        check_value("fa_ready_wait", fa_din_ready, 32'd1);
        fa_din = b;
        fa_din_valid = 1'b1;
        tick();
        fa_din_valid = 1'b0;
    endtask

    task automatic fb_expect(input string tag, input logic [7:0] exp);
        int n = 0;
        while (fb_dout_valid !== 1'b1 && n < 12 * FAST_SET) begin tick(); n++; end
        check_value({tag, "_valid"}, fb_dout_valid, 32'd1);
        check_value({tag, "_data"}, fb_dout, exp);
    endtask

    task automatic fb_consume(input string tag);
        fb_dout_ready = 1'b1;
        tick();
        fb_dout_ready = 1'b0;
        check_value({tag, "_cleared"}, fb_dout_valid, 32'd0);
    endtask

    // Full duplex at default rate: sa sends 0x7A, sb sends 0xA5 on the same edge.
    task automatic slow_duplex_test();
        logic [9:0] frame;
        int bad [10];
        int ready_low = 0;
        bit ready_back = 1'b0, got_a = 1'b0, got_b = 1'b0;
        logic [7:0] byte_a = 8'h00, byte_b = 8'h00;
        frame = {1'b1, 8'hA5, 1'b0};
        foreach (bad[i]) bad[i] = 0;
        sa_din = 8'h7A; sb_din = 8'hA5;
        sa_din_valid = 1'b1; sb_din_valid = 1'b1;
        tick();
        sa_din_valid = 1'b0; sb_din_valid = 1'b0;
        sb_din = 8'h00;
        for (int c = 0; c < 11 * SLOW_SET; c++) begin
            if (c < 10 * SLOW_SET && sb_tx !== frame[c / SLOW_SET]) bad[c / SLOW_SET]++;
            if (!ready_back) begin
                if (sb_din_ready === 1'b0) ready_low++;
                else ready_back = 1'b1;
            end
            if (!got_b && sb_dout_valid === 1'b1) begin got_b = 1'b1; byte_b = sb_dout; end
            if (!got_a && sa_dout_valid === 1'b1) begin got_a = 1'b1; byte_a = sa_dout; end
            tick();
        end
        for (int i = 0; i < 10; i++) check_value($sformatf("tx_a5_bit%0d", i), bad[i], 32'd0);
        check_value("tx_ready_low_cycles", ready_low, 10 * SLOW_SET);
        check_value("tx_idle_after", sb_tx, 32'd1);
        check_value("loop_7a_valid", got_b, 32'd1);
        check_value("loop_7a_data", byte_b, 32'h7A);
        if (got_b) $display("Got %h", byte_b);
        check_value("loop_a5_valid", got_a, 32'd1);
        check_value("loop_a5_data", byte_a, 32'hA5);
        sa_dout_ready = 1'b1; sb_dout_ready = 1'b1;
        tick();
        sa_dout_ready = 1'b0; sb_dout_ready = 1'b0;
        check_value("loop_sa_cleared", sa_dout_valid, 32'd0);
        check_value("loop_sb_cleared", sb_dout_valid, 32'd0);
    endtask

    // Short low pulse on an idle line, then a real 0x3C frame.
    task automatic slow_glitch_test();
        int seen = 0;
        int n = 0;
        glitch_en = 1'b1;
        glitch_line = 1'b0;
        repeat (100) tick();
        glitch_line = 1'b1;
        repeat (2 * SLOW_SET) begin
            if (sb_dout_valid === 1'b1) seen++;
            tick();
        end
        check_value("glitch_no_valid", seen, 32'd0);
        glitch_en = 1'b0;
        sa_din = 8'h3C;
        sa_din_valid = 1'b1;
        tick();
        sa_din_valid = 1'b0;
        while (sb_dout_valid !== 1'b1 && n < 11 * SLOW_SET) begin tick(); n++; end
        check_value("glitch_3c_valid", sb_dout_valid, 32'd1);
        check_value("glitch_3c_data", sb_dout, 32'h3C);
        sb_dout_ready = 1'b1;
        tick();
        sb_dout_ready = 1'b0;
    endtask

    task automatic fast_backpressure();
        int bad = 0;
        int seen = 0;
        fa_send(8'h11);
        fb_expect("bp_first", 8'h11);
        fa_send(8'h22);
        repeat (12 * FAST_SET) begin
            if (fb_dout_valid !== 1'b1 || fb_dout !== 8'h11) bad++;
            tick();
        end
        check_value("bp_hold", bad, 32'd0);
        fb_consume("bp");
        repeat (12 * FAST_SET) begin
            if (fb_dout_valid === 1'b1) seen++;
            tick();
        end
        check_value("bp_dropped", seen, 32'd0);
    endtask

    task automatic fast_back_to_back();
        fork
            begin
                int n = 0;
                fa_din = 8'h00;
                fa_din_valid = 1'b1;
                tick();
                while (fa_din_ready !== 1'b0 && n < 4) begin tick(); n++; end
                fa_din = 8'hFF;
                n = 0;
                while (fa_din_ready !== 1'b1 && n < 12 * FAST_SET) begin tick(); n++; end
                check_value("b2b_ready_back", fa_din_ready, 32'd1);
                tick();
                check_value("b2b_gap_ready", fa_din_ready, 32'd0);
                check_value("b2b_gap_start", fa_tx, 32'd0);
                fa_din_valid = 1'b0;
            end
            begin
                fb_expect("b2b_00", 8'h00);
                fb_consume("b2b_00");
                fb_expect("b2b_ff", 8'hFF);
                fb_consume("b2b_ff");
            end
        join
    endtask

    task automatic fast_reset_midframe();
        int seen = 0;
        fa_send(8'h55);
        repeat (5 * FAST_SET + FAST_SET / 2) tick();
        f_reset = 1'b1;
        tick();
        check_value("rstmid_serial_out", fa_tx, 32'd1);
        check_value("rstmid_ready", fa_din_ready, 32'd1);
        check_value("rstmid_rx_valid", fb_dout_valid, 32'd0);
        f_reset = 1'b0;
        repeat (12 * FAST_SET) begin
            if (fb_dout_valid === 1'b1) seen++;
            tick();
        end
        check_value("rstmid_no_delivery", seen, 32'd0);
    endtask

    // Random bytes A->B with random idle gaps and short random consume delays.
    task automatic fast_random(input int count);
        logic [7:0] exp_q [$];
        fork
            begin
                for (int i = 0; i < count; i++) begin
                    logic [7:0] b;
                    b = 8'($urandom_range(0, 255));
                    exp_q.push_back(b);
                    fa_send(b);
                    repeat ($urandom_range(0, FAST_SET)) tick();
                end
            end
            begin
                for (int k = 0; k < count; k++) begin
                    int n = 0;
                    logic [7:0] exp;
                    while (fb_dout_valid !== 1'b1 && n < 14 * FAST_SET) begin tick(); n++; end
                    check_value("rand_valid", fb_dout_valid, 32'd1);
                    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
                    check_value($sformatf("rand_data%0d", k), fb_dout, exp);
                    repeat ($urandom_range(0, 3)) tick();
                    fb_dout_ready = 1'b1;
                    tick();
                    fb_dout_ready = 1'b0;
                end
            end
        join
    endtask

    initial begin
        s_reset = 1'b1; f_reset = 1'b1;
        glitch_en = 1'b0; glitch_line = 1'b1;
        sa_din = 8'h00; sb_din = 8'h00; fa_din = 8'h00; fb_din = 8'h00;
        sa_din_valid = 1'b0; sb_din_valid = 1'b0; fa_din_valid = 1'b0; fb_din_valid = 1'b0;
        sa_dout_ready = 1'b0; sb_dout_ready = 1'b0; fa_dout_ready = 1'b0; fb_dout_ready = 1'b0;
        tick();
        tick();
        check_value("rst_serial_out", sa_tx, 32'd1);
        check_value("rst_ready", sa_din_ready, 32'd1);
        check_value("rst_valid", sb_dout_valid, 32'd0);
        check_value("rst_data", sb_dout, 32'd0);
        check_value("rst_fast_serial_out", fa_tx, 32'd1);
        s_reset = 1'b0;
        f_reset = 1'b0;
        tick();

        slow_duplex_test();
        slow_glitch_test();
        fast_backpressure();
        fast_back_to_back();
        fast_reset_midframe();
        fast_random(16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
